kab_int_ctrl: RTL
=================

# kab_int_ctrl

Parametrised external interrupt controller for the Kabeta IO subsystem. It accepts `NUM_SRC` maskable sources plus one non-maskable urgent source, each maskable source individually configurable as edge- or level-triggered. It arbitrates by fixed priority and presents one request/ID/acknowledge handshake to the processor. It occupies one IO block slot and exposes a small word-addressed register file through the standard IO register access ports.

## Interface
- `NUM_SRC`, default 8: number of maskable sources. Legal range is 1..31.
- `ID_W`, default `$clog2(NUM_SRC+1)`: width of the interrupt ID. Derived; do not override.
- `Sys_Clock`  in  1: single clock for all logic.
- `Sys_Reset`  in  1: synchronous, active-low reset.
- `Sys_BlockSelect`  in  1: this block is addressed.
- `Sys_RegAddress`  in  4: word register index.
- `Sys_WrEn`, `Sys_RdEn`  in  1 each: write and read strobes, single cycle, qualified by `Sys_BlockSelect`.
- `Sys_WrData`  in  32: write data.
- `Sys_RdData`  out  32: read data, registered.
- `IntSrc`  in  NUM_SRC: maskable source inputs.
- `UrgentSrc`  in  1: non-maskable source. Always edge-triggered.
- `EIC_IntReq`  out  1: interrupt request, registered.
- `EIC_IntId`  out  ID_W: ID of the requested source. Urgent source is ID `NUM_SRC`; maskable source i is ID i.
- `EIC_IntAck`  in  1: processor acknowledge.

## Operation
- Registers. Unlisted addresses read 0; writes to them are ignored.
  - 0 CTRL: bit0 = GEN, global enable for maskable sources.
  - 1 ENABLE: per-source mask, bits [NUM_SRC-1:0].
  - 2 MODE: per-source trigger mode, 1 = edge, 0 = level.
  - 3 PENDING: bits [NUM_SRC-1:0] are maskable pending; bit NUM_SRC is urgent pending. Reads return current state. Writing 1 clears edge-mode and urgent bits; writing to level-mode bits has no effect.
  - 4 ISR: read returns {bit31 = in-service valid, bits[ID_W-1:0] = in-service ID}. Any write is EOI and clears the in-service state.
  - 5 RAW: read returns the post-synchroniser source levels, with urgent at bit NUM_SRC.
- All registers reset to 0. Unused upper bits read 0.
- Pending behaviour:
  - Edge mode: a pending bit sets on a 0→1 transition of its (synchronised) source.
  - Level mode: a pending bit equals the source level.
  - Urgent: sets on a rising edge.
- Candidate selection, in priority order:
  - Urgent pending has highest priority.
  - Otherwise, the lowest-index source i with PENDING[i] & ENABLE[i] & GEN set.
- No nesting. While in-service is valid, no new request is raised, including urgent.
- EIC_IntReq/EIC_IntId next-state:
  - Next IntReq = candidate exists & !in-service & !(ack accepted this cycle).
  - IntId follows the candidate while IntReq is low. IntId is held stable while IntReq is high unless the candidate disappears (mask or clear), in which case IntReq drops and IntId is re-evaluated.
- Acknowledge:
  - An ack is accepted when EIC_IntAck is high and EIC_IntReq is high.
  - On acceptance: in-service is set to IntId. The pending bit for that ID is cleared if it is edge-mode or urgent.
  - EIC_IntAck while IntReq is low is ignored.
- Level sources: still high after EOI → a new request is raised.
- Simultaneous-event rules:
  - A new edge in the same cycle as a W1C or ack-clear of that bit: the set wins.
  - EOI in the same cycle as an ack: EOI is applied first, then the new in-service is set. In-service ends valid.
- EOI with no in-service valid is harmless.
- Reset asserted mid-handshake: all state returns to 0, IntReq goes low, and an outstanding ack is discarded.

## Timing
- Reset values: Sys_RdData = 0, EIC_IntReq = 0, EIC_IntId = 0. Synchroniser and edge-detect flops reset to 0, so sources already high at reset exit produce an edge.
- Read latency: Sys_RdData is valid on the cycle after a qualified Sys_RdEn and holds until the next read.
- Write latency: a write takes effect at the clock edge where Sys_WrEn is sampled.
- Source-rise to EIC_IntReq high:
  - 4 clocks with the synchroniser compiled in.
  - 2 clocks without it.
- Mask change: clearing ENABLE or GEN drops a pending request on the following clock edge.
- Ack acceptance: EIC_IntReq is low on the cycle after the ack edge. It remains low until EOI plus one clock, at minimum.

## Configuration
- `KAB_INTC_SYNC_EN` defined: `IntSrc` and `UrgentSrc` each pass through a 2-flop synchroniser before edge detection and RAW. Inputs may be asynchronous.
- Not defined: inputs feed edge detection directly and must be synchronous to Sys_Clock. All latencies in Timing shrink by 2 clocks.

## Test plan
- Edge priority: NUM_SRC=8, MODE=0xFF, ENABLE=0x14, GEN=1. Pulse IntSrc[4] and IntSrc[2] together → IntReq with IntId=2. Ack then EOI → IntReq with IntId=4. PENDING=0 at the end.
- Level re-request: MODE[3]=0, ENABLE[3]=1, hold IntSrc[3] high. Ack then EOI → IntReq reasserts with IntId=3. Drop the source, ack, EOI → no further request.
- Urgent preemption of arbitration: ENABLE=0, GEN=0, pulse UrgentSrc → IntReq, IntId=8. ISR after ack reads 0x80000008.
- Mask while requesting: IntReq high for ID 1, write ENABLE=0 → IntReq low next cycle. PENDING bit 1 stays set. Re-enable → IntReq with IntId=1.
- Boundaries:
  - Edge on IntSrc[0] in the same cycle as a W1C of PENDING bit 0 → bit stays 1.
  - Spurious EIC_IntAck with IntReq low → no state change.
  - Reset low during IntReq → all outputs 0 the next cycle.

Source files
------------

// File: rtl/kab_int_ctrl_if.sv
// Register-bus and processor interrupt handshake bundle for kab_int_ctrl.
// master: IO register bus / processor side. slave: interrupt controller side.
interface kab_int_ctrl_if #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC + 1)
);
    logic            Sys_BlockSelect;
    logic [3:0]      Sys_RegAddress;
    logic            Sys_WrEn;
    logic            Sys_RdEn;
    logic [31:0]     Sys_WrData;
    logic [31:0]     Sys_RdData;
    logic            EIC_IntReq;
    logic [ID_W-1:0] EIC_IntId;
    logic            EIC_IntAck;

    modport master (
        output Sys_BlockSelect, Sys_RegAddress, Sys_WrEn, Sys_RdEn, Sys_WrData, EIC_IntAck,
        input  Sys_RdData, EIC_IntReq, EIC_IntId
    );

    modport slave (
        input  Sys_BlockSelect, Sys_RegAddress, Sys_WrEn, Sys_RdEn, Sys_WrData, EIC_IntAck,
        output Sys_RdData, EIC_IntReq, EIC_IntId
    );
endinterface

// File: rtl/kab_int_ctrl.sv
// kab_int_ctrl: fixed-priority external interrupt controller with NUM_SRC
// maskable (edge/level) sources and one non-maskable edge-triggered urgent
// source. Optional feature macro KAB_INTC_SYNC_EN inserts a 2-flop
// synchroniser on all source inputs (default: inputs are used directly).
module kab_int_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic              Sys_Clock,
    input  logic              Sys_Reset,
    kab_int_ctrl_if.slave     bus,
    input  logic [NUM_SRC-1:0] IntSrc,
    input  logic              UrgentSrc
);
    localparam int N = NUM_SRC;
    localparam logic [3:0] ADDR_CTRL    = 4'd0;
    localparam logic [3:0] ADDR_ENABLE  = 4'd1;
    localparam logic [3:0] ADDR_MODE    = 4'd2;
    localparam logic [3:0] ADDR_PENDING = 4'd3;
    localparam logic [3:0] ADDR_ISR     = 4'd4;
    localparam logic [3:0] ADDR_RAW     = 4'd5;

    logic [N:0]      srcIn, srcS, srcPrev, srcRise;
    logic [N:0]      modeExt, pend, pendNext, elig, w1c, ackClr;
    logic [N-1:0]    en, mode;
    logic            gen;
    logic            isrValid;
    logic [ID_W-1:0] isrId, intId, idNext, candId;
    logic            intReq, reqNext, candValid, reqStill;
    logic            wrSel, rdSel, eoi, ackAcc;
    logic [31:0]     rdData, rdMux;
    logic            unusedWrBits;

    assign srcIn = {UrgentSrc, IntSrc};

`ifdef KAB_INTC_SYNC_EN
    logic [N:0] sync1, sync2;

    // Two-flop synchroniser for asynchronous source inputs
    always_ff @(posedge Sys_Clock) begin
        if (!Sys_Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= srcIn;
            sync2 <= sync1;
        end
    end
    assign srcS = sync2;
`else
    assign srcS = srcIn;
`endif

    assign srcRise      = srcS & ~srcPrev;
    assign modeExt      = {1'b1, mode};
    assign wrSel        = bus.Sys_BlockSelect & bus.Sys_WrEn;
    assign rdSel        = bus.Sys_BlockSelect & bus.Sys_RdEn;
    assign w1c          = (wrSel && bus.Sys_RegAddress == ADDR_PENDING) ? bus.Sys_WrData[N:0] : '0;
    assign eoi          = wrSel && bus.Sys_RegAddress == ADDR_ISR;
    assign ackAcc       = bus.EIC_IntAck & intReq;
    assign unusedWrBits = ^bus.Sys_WrData;

    assign bus.Sys_RdData = rdData;
    assign bus.EIC_IntReq = intReq;
    assign bus.EIC_IntId  = intId;

    // Arbitration, pending update and request/ID next-state
    always_comb begin
        elig      = {pend[N], pend[N-1:0] & en & {N{gen}}};
        candValid = |elig;
        candId    = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (elig[i-1]) candId = ID_W'(i - 1);
        end
        if (elig[N]) candId = ID_W'(N);

        reqStill = 1'b0;
        ackClr   = '0;
        for (int unsigned i = 0; i <= N; i++) begin
            if (intId == ID_W'(i)) begin
                reqStill  = elig[i];
                ackClr[i] = ackAcc & modeExt[i];
            end
        end

        // Edge bits: a new rise overrides a same-cycle W1C or ack clear.
        pendNext = (modeExt & (srcRise | (pend & ~(w1c | ackClr)))) | (~modeExt & srcS);

        // Held request keeps its ID; if its own source vanishes the request
        // drops for a cycle and the ID re-tracks the candidate.
        if (intReq && !ackAcc && reqStill) begin
            reqNext = 1'b1;
            idNext  = intId;
        end else if (intReq && !ackAcc) begin
            reqNext = 1'b0;
            idNext  = candId;
        end else begin
            reqNext = candValid & ~isrValid & ~ackAcc;
            idNext  = candId;
        end
    end

    // Register read multiplexer
    always_comb begin
        rdMux = '0;
        case (bus.Sys_RegAddress)
            ADDR_CTRL:    rdMux[0]      = gen;
            ADDR_ENABLE:  rdMux[N-1:0]  = en;
            ADDR_MODE:    rdMux[N-1:0]  = mode;
            ADDR_PENDING: rdMux[N:0]    = pend;
            ADDR_ISR: begin
                rdMux[31]       = isrValid;
                rdMux[ID_W-1:0] = isrId;
            end
            ADDR_RAW:     rdMux[N:0]    = srcS;
            default:      rdMux         = '0;
        endcase
    end

    // Source edge history, pending bits and processor handshake state
    always_ff @(posedge Sys_Clock) begin
        if (!Sys_Reset) begin
            srcPrev  <= '0;
            pend     <= '0;
            intReq   <= 1'b0;
            intId    <= '0;
            isrValid <= 1'b0;
            isrId    <= '0;
        end else begin
            srcPrev <= srcS;
            pend    <= pendNext;
            intReq  <= reqNext;
            intId   <= idNext;
            // Ack after EOI ordering: a same-cycle ack leaves in-service valid.
            if (ackAcc) begin
                isrValid <= 1'b1;
                isrId    <= intId;
            end else if (eoi) begin
                isrValid <= 1'b0;
                isrId    <= '0;
            end
        end
    end

    // Configuration register writes and registered read data
    always_ff @(posedge Sys_Clock) begin
        if (!Sys_Reset) begin
            gen    <= 1'b0;
            en     <= '0;
            mode   <= '0;
            rdData <= '0;
        end else begin
            if (wrSel) begin
                case (bus.Sys_RegAddress)
                    ADDR_CTRL:   gen  <= bus.Sys_WrData[0];
                    ADDR_ENABLE: en   <= bus.Sys_WrData[N-1:0];
                    ADDR_MODE:   mode <= bus.Sys_WrData[N-1:0];
                    default:     ;
                endcase
            end
            if (rdSel) rdData <= rdMux;
        end
    end
endmodule
